// File: rtl/seq_det_pkg.sv
// Shared constants and state encoding for the word-to-serial sequence detector.
package seq_det_pkg;

  localparam int                    WORD_W_DEF  = 5;
  localparam logic [WORD_W_DEF-1:0] PATTERN_DEF = 5'b00110;
  localparam int                    CNT_W_DEF   = 8;
  localparam int                    HITS_W_DEF  = $clog2(WORD_W_DEF + 1);

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  function automatic int hits_w(input int word_w);
    return $clog2(word_w + 1);
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// Serial Mealy pattern detector: shift history of the last WORD_W-1 bits plus a
// fill counter so no match is reported before a full window has been seen.
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int                WORD_W  = WORD_W_DEF,
  parameter logic [WORD_W-1:0] PATTERN = PATTERN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sbit,
  input  logic valid,
  input  logic flush,
  output logic det
);

  localparam int                FILL_W   = $clog2(WORD_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WORD_W - 1);

  logic [WORD_W-2:0] hist;
  logic [FILL_W-1:0] fill;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hist <= '0;
      fill <= '0;
    end else if (valid) begin
      hist <= {hist[WORD_W-3:0], sbit};
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

  // Oldest history bit lines up with PATTERN's MSB, the current bit with its LSB.
  assign det = valid && (fill == FILL_MAX) && ({hist, sbit} == PATTERN);

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-to-serial sequencer feeding seq_det_core; counts hits per word and overall.
// Define FLUSH_ON_WORD_EN to clear detector history on every accepted word.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int                WORD_W  = WORD_W_DEF,
  parameter logic [WORD_W-1:0] PATTERN = PATTERN_DEF,
  parameter int                CNT_W   = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WORD_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic                         clear_cnt,
  output logic                         ser_bit,
  output logic                         ser_valid,
  output logic                         det,
  output logic                         word_done,
  output logic [$clog2(WORD_W+1)-1:0]  word_hits,
  output logic [CNT_W-1:0]             hit_count,
  output logic                         busy
);

  localparam int               HW      = $clog2(WORD_W + 1);
  localparam int               IDX_W   = $clog2(WORD_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WORD_W - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] word;
  logic [HW-1:0]     whits;
  logic              accept;
  logic              flush;

  assign accept    = (state == S_IDLE) && in_valid;
  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign ser_valid = (state == S_SHIFT);
  assign ser_bit   = ser_valid & word[idx];
  assign word_done = (state == S_DONE);
  assign word_hits = word_done ? whits : '0;

`ifdef FLUSH_ON_WORD_EN
  assign flush = accept;
`else
  assign flush = 1'b0;
`endif

  seq_det_core #(.WORD_W(WORD_W), .PATTERN(PATTERN)) u_core (
    .clk   (clk),
    .rst   (rst),
    .sbit  (ser_bit),
    .valid (ser_valid),
    .flush (flush),
    .det   (det)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      word  <= '0;
      whits <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          word  <= in_data;
          idx   <= '0;
          whits <= '0;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          idx <= idx + 1'b1;
          if (det) whits <= whits + 1'b1;
          if (idx == IDX_MAX) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Clear beats a coincident hit; the per-word count above still sees it.
  always_ff @(posedge clk) begin
    if (rst || clear_cnt)                hit_count <= '0;
    else if (det && (hit_count != '1))   hit_count <= hit_count + 1'b1;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Sequencer for the bit-serial sequence detector datapath.
- Accepts parallel words over a valid/ready handshake and serializes each word LSB-first into an embedded Mealy pattern detector.
- Reports per-word hit counts and keeps a saturating running total.
- Sits between a word-oriented producer (bus or register block) and the serial detector.

Parameters:
- WORD_W, 5, bits per input word and pattern length.
- PATTERN, 5'b00110, target sequence; PATTERN[WORD_W-1] is the first bit received in time.
- CNT_W, 8, width of the running hit counter.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer has a word.
- in_data  input  WORD_W  word to serialize; bit 0 is sent first.
- in_ready  output  1  controller can accept a word.
- clear_cnt  input  1  synchronous clear of hit_count.
- ser_bit  output  1  current serial bit.
- ser_valid  output  1  ser_bit is being presented to the detector this cycle.
- det  output  1  Mealy detect; combinational from ser_bit, ser_valid and history.
- word_done  output  1  one-cycle pulse: the word has been fully shifted.
- word_hits  output  $clog2(WORD_W+1)  hits within the finished word; valid while word_done=1.
- hit_count  output  CNT_W  saturating total of hits.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, bit index=0, shift word=0, history=0, history-fill=0, word_hits=0, hit_count=0.
  - All outputs 0 except in_ready=1.
  - Reset mid-word discards the in-flight word; no word_done is issued.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data, clear idx and the per-word hit counter, go to SHIFT.
- SHIFT:
  - in_ready=0, ser_valid=1, ser_bit=word[idx].
  - Each cycle: history <= {history[WORD_W-3:0], ser_bit} and idx increments.
  - When idx==WORD_W-1, go to DONE.
- DONE:
  - word_done=1, word_hits=per-word count, in_ready=0.
  - Next cycle returns to IDLE.
- Throughput: accept edge E, ser_valid high for cycles E+1..E+WORD_W, word_done in cycle E+WORD_W+1, in_ready high in cycle E+WORD_W+2. A 5-bit word takes 7 cycles.
- Detector:
  - det = ser_valid && fill>=WORD_W-1 && ({history, ser_bit}==PATTERN). history holds the last WORD_W-1 bits, oldest in the MSB.
  - Overlapping matches are counted.
  - History persists across words, so matches may span a word boundary and count in the word where they complete.
  - fill saturates at WORD_W-1.
- Counters:
  - The per-word counter increments on det; it cannot overflow.
  - hit_count increments on det and saturates at 2^CNT_W-1.
  - If clear_cnt and det occur in the same cycle, clear wins and the hit is dropped from hit_count. The per-word count still includes it.
- in_data is sampled only at the accept edge; later changes are ignored.

Optional Feature:
- Macro FLUSH_ON_WORD_EN.
- Defined: history and fill are cleared on every accept, so no match spans a word boundary.
- Undefined: streaming behaviour as described above.

Decomposition:
- Package seq_det_pkg holds:
  - the state enum (IDLE/SHIFT/DONE),
  - default WORD_W, PATTERN and CNT_W constants,
  - the derived hit-count width.
- Sub-module seq_det_core contains history, fill and det, with inputs clk, rst, bit, valid and flush. The controller instantiates it once.

Test Plan:
- Reset then idle: rst for 2 cycles, no in_valid -> in_ready=1, busy=0, all other outputs 0, hit_count=0.
- Single match: in_data=5'b01100 (bits sent 0,0,1,1,0) after a fresh reset -> det=1 only in the 5th SHIFT cycle; word_done with word_hits=1; hit_count=1; in_ready back 7 cycles after accept.
- Boundary span: words 5'b11000 then 5'b11110 -> first word_hits=0, second word_hits=1 (det on its first bit), hit_count=1. With FLUSH_ON_WORD_EN: second word_hits=0, hit_count=0.
- Overlap and back-to-back: in_valid held high with 5'b01100 then 5'b01100 -> second accept occurs exactly when in_ready rises; hits at serial bits 5 and 10; hit_count=2. No accept while busy.
- Saturation and clear: CNT_W=2, send 4 single-match words -> hit_count sticks at 3. Assert clear_cnt in the cycle det=1 -> hit_count=0 next cycle.
- Reset mid-word: assert rst during the 3rd SHIFT cycle -> no word_done; next word 5'b01100 gives word_hits=1, proving history was cleared.
